// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  localparam int LOSS_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// rtl/lock_sync.sv - two-flop synchronizer for the asynchronous PLL lock signal.
module lock_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification and retry control.
// Define PLL_SUP_LOSS_CNT_EN to build the lock-loss event counter.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_HOLD_CYC     = 16,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRY        = 3
) (
  input  logic                           clkin,
  input  logic                           reset,
  input  logic                           lock_i,
  input  logic                           relock_req_i,
  output logic                           pll_reset_o,
  output logic                           rst_out_o,
  output logic                           ready_o,
  output logic                           fail_o,
  output logic [$clog2(MAX_RETRY+2)-1:0] retry_cnt_o,
  output logic [LOSS_CNT_W-1:0]          loss_cnt_o
);

  localparam int TMAX = max3(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int RW   = $clog2(MAX_RETRY + 2);

  localparam logic [TW-1:0] HOLD_LAST    = TW'(RST_HOLD_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY);

  logic lock_s;

  lock_sync u_lock_sync (
    .clk_i   (clkin),
    .rst_i   (reset),
    .async_i (lock_i),
    .sync_o  (lock_s)
  );

  pll_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          attempt_fail;
  logic          pll_reset_q, pll_reset_d;
  logic          rst_out_q, rst_out_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= RST_PLL;
      timer_q     <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      rst_out_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  // One timer serves every timed state; it is cleared on each state entry.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    attempt_fail = 1'b0;
    case (state_q)
      RST_PLL: begin
        if (timer_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          attempt_fail = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          attempt_fail = 1'b1;
        end else if (timer_q == STABLE_LAST) begin
          state_d = RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = RST_PLL;
          timer_d = '0;
          retry_d = '0;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = RST_PLL;
        timer_d = '0;
      end
    endcase

    if (attempt_fail) begin
      retry_d = retry_q + 1'b1;
      timer_d = '0;
      state_d = (retry_q == RETRY_LAST) ? FAIL : RST_PLL;
    end

    // A relock request overrides everything except an attempt already in reset.
    if (relock_req_i && (state_q != RST_PLL)) begin
      state_d = RST_PLL;
      timer_d = '0;
      retry_d = '0;
    end
  end

  always_comb begin
    pll_reset_d = (state_d == RST_PLL) || (state_d == FAIL);
    rst_out_d   = (state_d != RUN);
    ready_d     = (state_d == RUN);
    fail_d      = (state_d == FAIL);
  end

  assign pll_reset_o = pll_reset_q;
  assign rst_out_o   = rst_out_q;
  assign ready_o     = ready_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  // A loss coinciding with a relock request is not an event.
  always_comb begin
    loss_d = loss_q;
    if ((state_q == RUN) && !lock_s && !relock_req_i && (loss_q != '1)) begin
      loss_d = loss_q + 1'b1;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_cnt_o = loss_q;
`else
  assign loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed table and sequence checks for pll_lock_supervisor.
module tb_pll_lock_supervisor;

  localparam int H = 4;
  localparam int T = 20;
  localparam int S = 8;
  localparam int M = 2;
`ifdef PLL_SUP_LOSS_CNT_EN
  localparam int LOSS_ON = 1;
`else
  localparam int LOSS_ON = 0;
`endif

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       lock_i = 1'b0;
  logic       relock_req_i = 1'b0;
  logic       pll_reset_o, rst_out_o, ready_o, fail_o;
  logic [1:0] retry_cnt_o;
  logic [7:0] loss_cnt_o;

  pll_lock_supervisor #(
    .RST_HOLD_CYC     (H),
    .LOCK_TIMEOUT_CYC (T),
    .LOCK_STABLE_CYC  (S),
    .MAX_RETRY        (M)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .lock_i       (lock_i),
    .relock_req_i (relock_req_i),
    .pll_reset_o  (pll_reset_o),
    .rst_out_o    (rst_out_o),
    .ready_o      (ready_o),
    .fail_o       (fail_o),
    .retry_cnt_o  (retry_cnt_o),
    .loss_cnt_o   (loss_cnt_o)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic rst;
    logic lock;
    logic relock;
    int   n;
    logic e_pll;
    logic e_rsto;
    logic e_rdy;
    logic e_fail;
    int   e_retry;
  } vec_t;

  vec_t vecs[20];
  int   total = 0;
  int   bad = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic pll, input logic rsto,
                          input logic rdy, input logic fl, input int retry);
    chk({tag, ".pll_reset"}, 32'(pll_reset_o), 32'(pll));
    chk({tag, ".rst_out"},   32'(rst_out_o),   32'(rsto));
    chk({tag, ".ready"},     32'(ready_o),     32'(rdy));
    chk({tag, ".fail"},      32'(fail_o),      32'(fl));
    chk({tag, ".retry"},     32'(retry_cnt_o), 32'(retry));
  endtask

  task automatic count_pll_high(output int n);
    n = 0;
    while (pll_reset_o === 1'b1 && n < 200) begin
      n++;
      tick(1);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready_o !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n;
    logic rdy_seen;

    // Timeout exhaustion, FAIL, relock, relock ignored in RST_PLL, timeout/lock race.
    // Fields: rst lock relock cycles | pll rst_out ready fail retry
    vecs[0]  = '{1'b1, 1'b0, 1'b0,  2, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 19, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 19, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    vecs[9]  = '{1'b0, 1'b0, 1'b0,  4, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 19, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    vecs[11] = '{1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b1, 3};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 28, 1'b1, 1'b1, 1'b0, 1'b1, 3};
    vecs[13] = '{1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[14] = '{1'b0, 1'b0, 1'b1,  2, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[15] = '{1'b0, 1'b0, 1'b0,  2, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[16] = '{1'b1, 1'b0, 1'b0,  2, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 21, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[18] = '{1'b0, 1'b1, 1'b0,  3, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[19] = '{1'b0, 1'b1, 1'b0,  8, 1'b0, 1'b0, 1'b1, 1'b0, 0};

    // Normal bring-up from reset.
    tick(2);
    chk_outs("reset", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk("reset.loss", 32'(loss_cnt_o), 32'd0);
    reset = 1'b0;
    count_pll_high(n);
    chk("bringup.pll_pulse_len", 32'(n), 32'(H));
    lock_i = 1'b1;
    wait_ready(n);
    chk("bringup.lock_to_ready", 32'(n), 32'(S + 3));
    chk_outs("bringup.run", 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Loss of lock in RUN.
    tick(3);
    lock_i = 1'b0;
    n = 0;
    while (rst_out_o !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    chk("loss.fall_to_rst_out", 32'(n), 32'd3);
    chk_outs("loss.after", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk("loss.loss_cnt", 32'(loss_cnt_o), 32'(LOSS_ON));
    lock_i = 1'b1;
    wait_ready(n);
    chk("loss.relock_ready", 32'(ready_o), 32'd1);

    // Relock request coinciding with the loss as seen by the FSM: loss not counted.
    lock_i = 1'b0;
    tick(2);
    relock_req_i = 1'b1;
    tick(1);
    relock_req_i = 1'b0;
    chk_outs("prio.after", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk("prio.loss_cnt", 32'(loss_cnt_o), 32'(LOSS_ON));

    // Into STABLE, then mid-operation reset.
    lock_i = 1'b1;
    tick(6);
    chk_outs("stable", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    reset = 1'b1;
    tick(1);
    chk_outs("midreset", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk("midreset.loss", 32'(loss_cnt_o), 32'd0);
    reset = 1'b0;
    lock_i = 1'b0;
    count_pll_high(n);
    chk("midreset.pll_pulse_len", 32'(n), 32'(H));

    // Lock glitch during STABLE: high 5 cycles, low 1, high again.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    rdy_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      lock_i = (k >= 4) && (k != 9);
      tick(1);
      rdy_seen |= ready_o;
    end
    chk_outs("glitch.fail", 1'b1, 1'b1, 1'b0, 1'b0, 1);
    n = 0;
    while (pll_reset_o === 1'b1 && n < 200) begin
      n++;
      tick(1);
      rdy_seen |= ready_o;
    end
    chk("glitch.pll_pulse_len", 32'(n), 32'(H));
    chk("glitch.ready_seen", 32'(rdy_seen), 32'd0);

    // Table-driven vectors.
    reset = 1'b1;
    lock_i = 1'b0;
    tick(2);
    for (int i = 0; i < 20; i++) begin
      reset = vecs[i].rst;
      lock_i = vecs[i].lock;
      relock_req_i = vecs[i].relock;
      tick(vecs[i].n);
      chk_outs($sformatf("vec%0d", i), vecs[i].e_pll, vecs[i].e_rsto,
               vecs[i].e_rdy, vecs[i].e_fail, vecs[i].e_retry);
    end
    relock_req_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
